// File: rtl/uart_mmio.sv
// Memory-mapped UART on the data-memory port: STATUS/RXDATA/TXDATA registers with 1-cycle load latency.
// Define MMIO_RX_FIFO_EN to replace the single RX holding register with an RX_FIFO_DEPTH-entry FIFO.
module uart_mmio #(
    parameter int CLKS_PER_BIT  = 868,
    parameter int RX_FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  we,
    input  logic        re,
    input  logic [31:0] wdata,
    output logic        hit,
    output logic [31:0] rdata,
    input  logic        serial_in,
    output logic        serial_out
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [1:0] offset;
    logic       rd_status, rd_rxdata, wr_txdata;
    logic       unused_bits;

    assign hit         = (addr[31:28] == 4'h8);
    assign offset      = addr[3:2];
    assign unused_bits = ^{addr[27:4], addr[1:0], we[3:1], wdata[31:8]};

    always_comb begin
        rd_status = hit & re & (offset == 2'd0);
        rd_rxdata = hit & re & (offset == 2'd1);
        wr_txdata = hit & we[0] & (offset == 2'd2);
    end

    state_t           tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             serial_out_q, serial_out_d;
    logic             tx_ready_q, tx_ready_d;

    always_comb begin
        tx_state_d   = tx_state_q;
        tx_cnt_d     = tx_cnt_q;
        tx_bit_d     = tx_bit_q;
        tx_shift_d   = tx_shift_q;
        serial_out_d = serial_out_q;
        tx_ready_d   = tx_ready_q;
        case (tx_state_q)
            S_IDLE: begin
                if (wr_txdata && tx_ready_q) begin
                    tx_shift_d   = wdata[7:0];
                    serial_out_d = 1'b0;
                    tx_ready_d   = 1'b0;
                    tx_cnt_d     = '0;
                    tx_state_d   = S_START;
                end
            end
            S_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d     = '0;
                    tx_bit_d     = 3'd0;
                    serial_out_d = tx_shift_q[0];
                    tx_state_d   = S_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        serial_out_d = 1'b1;
                        tx_state_d   = S_STOP;
                    end else begin
                        tx_bit_d     = tx_bit_q + 3'd1;
                        tx_shift_d   = {1'b0, tx_shift_q[7:1]};
                        serial_out_d = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_ready_d = 1'b1;
                    tx_state_d = S_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_W'(1);
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q   <= S_IDLE;
            tx_cnt_q     <= '0;
            tx_bit_q     <= '0;
            tx_shift_q   <= '0;
            serial_out_q <= 1'b1;
            tx_ready_q   <= 1'b1;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_bit_q     <= tx_bit_d;
            tx_shift_q   <= tx_shift_d;
            serial_out_q <= serial_out_d;
            tx_ready_q   <= tx_ready_d;
        end
    end

    assign serial_out = serial_out_q;

    // serial_in is asynchronous; only rx_sync_q is used by the receiver.
    logic rx_meta_q, rx_sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= serial_in;
            rx_sync_q <= rx_meta_q;
        end
    end

    state_t           rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             rx_deliver, ferr_set;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_deliver = 1'b0;
        ferr_set   = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                if (!rx_sync_q) begin
                    rx_cnt_d   = '0;
                    rx_state_d = S_START;
                end
            end
            S_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = S_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = S_IDLE;
                    rx_deliver = rx_sync_q;
                    ferr_set   = !rx_sync_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_W'(1);
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    logic       rx_valid;
    logic [7:0] rx_head;
    logic       overrun_set;

`ifdef MMIO_RX_FIFO_EN
    localparam int PTR_W = $clog2(RX_FIFO_DEPTH);

    logic [7:0] fifo_q [RX_FIFO_DEPTH];
    logic [7:0] fifo_d [RX_FIFO_DEPTH];
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic fifo_empty, fifo_full, rx_pop;

    // Extra pointer bit distinguishes full (MSBs differ) from empty (all equal).
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign rx_valid   = !fifo_empty;
    assign rx_head    = fifo_q[rd_ptr_q[PTR_W-1:0]];
    assign rx_pop     = rd_rxdata && !fifo_empty;

    always_comb begin
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overrun_set = 1'b0;
        if (rx_pop) begin
            rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        end
        if (rx_deliver) begin
            if (!fifo_full || rx_pop) begin
                fifo_d[wr_ptr_q[PTR_W-1:0]] = rx_shift_q;
                wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
            end else begin
                overrun_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_q   <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
`else
    localparam int unused_fifo_depth = RX_FIFO_DEPTH;

    logic       rx_valid_q, rx_valid_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_pop;

    assign rx_valid = rx_valid_q;
    assign rx_head  = rx_byte_q;
    assign rx_pop   = rd_rxdata && rx_valid_q;

    // A same-edge read frees the register, so the new byte is accepted.
    always_comb begin
        rx_valid_d  = rx_valid_q;
        rx_byte_d   = rx_byte_q;
        overrun_set = 1'b0;
        if (rx_pop) begin
            rx_valid_d = 1'b0;
        end
        if (rx_deliver) begin
            if (!rx_valid_q || rx_pop) begin
                rx_byte_d  = rx_shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_set = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_valid_q <= 1'b0;
            rx_byte_q  <= '0;
        end else begin
            rx_valid_q <= rx_valid_d;
            rx_byte_q  <= rx_byte_d;
        end
    end
`endif

    logic        ferr_q, ferr_d, overrun_q, overrun_d;
    logic [31:0] rdata_q, rdata_d;

    always_comb begin
        ferr_d    = ferr_q;
        overrun_d = overrun_q;
        if (rd_status) begin
            ferr_d    = 1'b0;
            overrun_d = 1'b0;
        end
        if (ferr_set)    ferr_d    = 1'b1;
        if (overrun_set) overrun_d = 1'b1;

        rdata_d = '0;
        if (hit && re) begin
            case (offset)
                2'd0:    rdata_d = {28'b0, overrun_q, ferr_q, rx_valid, tx_ready_q};
                2'd1:    rdata_d = {24'b0, rx_head};
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            ferr_q    <= ferr_d;
            overrun_q <= overrun_d;
            rdata_q   <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: tb/tb_uart_mmio.sv
// Scoreboard bench for uart_mmio with CLKS_PER_BIT=8: register reads, TX line timing, RX framing and reset.
module tb_uart_mmio;

    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [3:0]  we;
    logic        re;
    logic [31:0] wdata;
    logic        hit;
    logic [31:0] rdata;
    logic        serial_in;
    logic        serial_out;

    int checks = 0;
    int errors = 0;
    int cycle_cnt = 0;
    logic [31:0] exp_q[$];

    uart_mmio #(.CLKS_PER_BIT(CPB), .RX_FIFO_DEPTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .we         (we),
        .re         (re),
        .wdata      (wdata),
        .hit        (hit),
        .rdata      (rdata),
        .serial_in  (serial_in),
        .serial_out (serial_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
        end
    endtask

    // Returns 1 time unit after the posedge that brings cycle_cnt to n.
    task automatic waitUntil(input int n);
        while (cycle_cnt < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bus cycle; for loads the expected value is queued and compared once rdata is registered.
    task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [3:0] w,
                                 input logic r, input logic [31:0] d, input logic [31:0] expected);
        @(negedge clk);
        addr  = a;
        we    = w;
        re    = r;
        wdata = d;
        if (r) exp_q.push_back(expected);
        @(posedge clk);
        #1;
        addr  = '0;
        we    = '0;
        re    = 1'b0;
        wdata = '0;
        if (r) begin
            if (exp_q.size() == 0) checkOutput({tag, "_queue"}, 32'd0, 32'd1);
            else checkOutput(tag, rdata, exp_q.pop_front());
        end
    endtask

    task automatic readReg(input string tag, input logic [1:0] off, input logic [31:0] expected);
        applyStimulus(tag, 32'h8000_0000 | (32'(off) << 2), 4'b0000, 1'b1, 32'd0, expected);
    endtask

    task automatic writeTx(input logic [7:0] b);
        applyStimulus("tx_write", 32'h8000_0008, 4'b0001, 1'b0, {24'hFFFF_FF, b}, 32'd0);
    endtask

    task automatic sendFrame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            serial_in = bits[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk);
        serial_in = 1'b1;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycle_cnt);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int p0;
        int base;
        logic [9:0] tx_bits;

        reset     = 1'b1;
        addr      = '0;
        we        = '0;
        re        = 1'b0;
        wdata     = '0;
        serial_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rdata", rdata, 32'd0);
        checkOutput("reset_serial_out", {31'd0, serial_out}, 32'd1);
        @(negedge clk);
        reset = 1'b0;

        addr = 32'h8000_0004;
        #1;
        checkOutput("hit_high", {31'd0, hit}, 32'd1);
        addr = 32'h7FFF_FFFC;
        #1;
        checkOutput("hit_low", {31'd0, hit}, 32'd0);
        addr = '0;

        readReg("status_idle", 2'd0, 32'h1);
        readReg("reserved_read", 2'd3, 32'h0);
        readReg("status_idle2", 2'd0, 32'h1);
        applyStimulus("miss_read", 32'h0000_0000, 4'b0000, 1'b1, 32'd0, 32'h0);

        // TX frame 0xA5, with a dropped write and STATUS polls while busy
        writeTx(8'hA5);
        p0 = cycle_cnt;
        tx_bits = {1'b1, 8'hA5, 1'b0};
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    waitUntil(p0 + 8 * k + 4);
                    checkOutput($sformatf("tx_bit%0d", k), {31'd0, serial_out}, {31'd0, tx_bits[k]});
                end
            end
            begin
                waitUntil(p0 + 19);
                writeTx(8'hFF);
                waitUntil(p0 + 29);
                readReg("status_tx_busy", 2'd0, 32'h0);
                waitUntil(p0 + 78);
                readReg("status_tx_last", 2'd0, 32'h0);
                waitUntil(p0 + 80);
                readReg("status_tx_done", 2'd0, 32'h1);
            end
        join
        waitUntil(p0 + 100);
        checkOutput("tx_idle_after", {31'd0, serial_out}, 32'd1);

        // Good RX frame
        sendFrame(8'h3C, 1'b1);
        waitUntil(cycle_cnt + 4);
        readReg("rx_status_valid", 2'd0, 32'h3);
        readReg("rx_data_3c", 2'd1, 32'h3C);
        readReg("rx_status_empty", 2'd0, 32'h1);

        // Framing error
        sendFrame(8'h7E, 1'b0);
        waitUntil(cycle_cnt + 12);
        readReg("ferr_status", 2'd0, 32'h5);
        readReg("ferr_cleared", 2'd0, 32'h1);

        // Two frames without an intervening read
        sendFrame(8'h11, 1'b1);
        sendFrame(8'h22, 1'b1);
        waitUntil(cycle_cnt + 4);
`ifdef MMIO_RX_FIFO_EN
        readReg("fifo_status", 2'd0, 32'h3);
        readReg("fifo_first", 2'd1, 32'h11);
        readReg("fifo_second", 2'd1, 32'h22);
        readReg("fifo_drained", 2'd0, 32'h1);
`else
        readReg("ovr_status", 2'd0, 32'hB);
        readReg("ovr_data_kept", 2'd1, 32'h11);
        readReg("ovr_cleared", 2'd0, 32'h1);
`endif

        // RXDATA read on the same edge as a delivery: pop then push
        sendFrame(8'h11, 1'b1);
        waitUntil(cycle_cnt + 4);
        base = cycle_cnt;
        fork
            sendFrame(8'h22, 1'b1);
            begin
                waitUntil(base + 78);
                readReg("same_edge_pop", 2'd1, 32'h11);
            end
        join
        waitUntil(cycle_cnt + 2);
        readReg("same_edge_status", 2'd0, 32'h3);
        readReg("same_edge_data", 2'd1, 32'h22);
        readReg("same_edge_empty", 2'd0, 32'h1);

        // Short low glitch must not start a frame
        @(negedge clk);
        serial_in = 1'b0;
        repeat (3) @(negedge clk);
        serial_in = 1'b1;
        waitUntil(cycle_cnt + 20);
        readReg("glitch_status", 2'd0, 32'h1);

        // Reset in the middle of a TX frame
        writeTx(8'h00);
        p0 = cycle_cnt;
        waitUntil(p0 + 30);
        checkOutput("tx_mid_frame_low", {31'd0, serial_out}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset_mid_tx_line", {31'd0, serial_out}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        readReg("reset_mid_tx_status", 2'd0, 32'h1);
        waitUntil(cycle_cnt + 20);
        checkOutput("reset_mid_tx_idle", {31'd0, serial_out}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
